// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmit byte port among NUM_REQ requesters.
// A stall timeout force-releases a lock whose owner stops supplying bytes mid-packet.
//
// state  | meaning
// IDLE   | no owner; arbitrate among valid requesters (no byte moves this cycle)
// LOCKED | owner's ready/valid path routed to the UART until its last byte or a stall timeout
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 125_000_000,
   parameter int ID_W           = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ*8-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic                   busy,
   output logic [ID_W-1:0]        grant_id,
   output logic                   timeout
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] STALL_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t          state;
   logic [ID_W-1:0] owner;
   logic [ID_W-1:0] last_grant;
   logic [31:0]     stall_cnt;
   logic [7:0]      req_bytes [NUM_REQ];
   logic [ID_W-1:0] cand;
   logic [ID_W-1:0] pick_idx;
   logic            pick_found;
   logic            handshake;
   logic            stall_hit;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
      assign req_bytes[g] = req_data[g*8 +: 8];
   end

   // first valid requester after the previous owner, wrapping around
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      tx_valid  = 1'b0;
      tx_data   = req_bytes[owner];
      if (state == LOCKED) begin
         tx_valid         = req_valid[owner];
         req_ready[owner] = tx_ready;
      end
   end

   assign handshake = (state == LOCKED) && req_valid[owner] && tx_ready;
   assign stall_hit = TIMEOUT_EN && (stall_cnt == STALL_LAST);
   assign busy      = (state == LOCKED);
   assign grant_id  = owner;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         owner      <= '0;
         stall_cnt  <= '0;
         timeout    <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  owner     <= pick_idx;
                  state     <= LOCKED;
                  stall_cnt <= '0;
               end
            end
            LOCKED: begin
               if (handshake) begin
                  stall_cnt <= '0;
                  if (req_last[owner]) begin
                     state      <= IDLE;
                     last_grant <= owner;
                  end
               end else if (!req_valid[owner]) begin
                  // UART backpressure (valid high, ready low) neither counts nor clears
                  if (stall_hit) begin
                     state      <= IDLE;
                     last_grant <= owner;
                     stall_cnt  <= '0;
                     timeout    <= 1'b1;
                  end else if (TIMEOUT_EN) begin
                     stall_cnt <= stall_cnt + 32'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic against a
// packet-queue reference model of the round-robin / lock / stall-timeout rules.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 16;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [N*8-1:0] req_data;
   logic [N-1:0]   req_valid, req_last, req_ready;
   logic [7:0]     tx_data;
   logic           tx_valid, tx_ready, busy, timeout;
   logic [IW-1:0]  grant_id;

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO), .ID_W(IW)) dut (
      .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
      .grant_id(grant_id), .timeout(timeout));

   always #5 clk = ~clk;

   bit         drv_valid [N];
   bit         drv_last  [N];
   logic [7:0] drv_data  [N];
   for (genvar g = 0; g < N; g++) begin : g_drv
      assign req_valid[g]        = drv_valid[g];
      assign req_last[g]         = drv_last[g];
      assign req_data[g*8 +: 8]  = drv_data[g];
   end

   int n_checks = 0;
   int n_fail   = 0;

   // pending packet bytes per requester
   logic [7:0] q_data [N][$];
   bit         q_last [N][$];

   bit m_locked, m_tpulse;
   int m_owner, m_last, m_stall;
   int rdy_mode;
   bit gaps;
   int cyc, busy_cycles, rdy2_bad, pushed;
   int         log_id [$];
   logic [7:0] log_byte [$];
   int         log_cyc [$];
   int         to_cyc [$];

   task automatic model_reset();
      m_locked = 0; m_tpulse = 0; m_owner = 0; m_last = N - 1; m_stall = 0;
      for (int i = 0; i < N; i++) begin
         q_data[i].delete();
         q_last[i].delete();
      end
      log_id.delete(); log_byte.delete(); log_cyc.delete(); to_cyc.delete();
      cyc = 0; busy_cycles = 0; rdy2_bad = 0; pushed = 0;
   endtask

   task automatic push(input int r, input logic [7:0] d, input bit l);
      q_data[r].push_back(d);
      q_last[r].push_back(l);
      pushed++;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (q_data[i].size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
            drv_valid[i] = 1'b1; drv_data[i] = q_data[i][0]; drv_last[i] = q_last[i][0];
         end else begin
            drv_valid[i] = 1'b0; drv_data[i] = 8'h00; drv_last[i] = 1'b0;
         end
      end
      tx_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         drv_valid[i] = 1'b0; drv_data[i] = 8'h00; drv_last[i] = 1'b0;
      end
      tx_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   // one clock: drive, compare against the reference model at negedge, advance the model
   task automatic step();
      bit         exp_valid, hs, found, lst;
      logic [N-1:0] exp_ready;
      int         idx;
      drive_inputs();
      @(negedge clk);
      exp_valid = m_locked && drv_valid[m_owner];
      exp_ready = (m_locked && tx_ready) ? (N'(1) << m_owner) : '0;
      n_checks += 5;
      if (tx_valid !== exp_valid) begin
         n_fail++; $display("FAIL model_tx_valid cyc=%0d: got %b expected %b", cyc, tx_valid, exp_valid);
      end
      if (req_ready !== exp_ready) begin
         n_fail++; $display("FAIL model_req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
      end
      if (busy !== m_locked) begin
         n_fail++; $display("FAIL model_busy cyc=%0d: got %b expected %b", cyc, busy, m_locked);
      end
      if (grant_id !== IW'(m_owner)) begin
         n_fail++; $display("FAIL model_grant_id cyc=%0d: got %0d expected %0d", cyc, grant_id, m_owner);
      end
      if (timeout !== m_tpulse) begin
         n_fail++; $display("FAIL model_timeout cyc=%0d: got %b expected %b", cyc, timeout, m_tpulse);
      end
      if (exp_valid) begin
         n_checks++;
         if (tx_data !== q_data[m_owner][0]) begin
            n_fail++; $display("FAIL model_tx_data cyc=%0d: got %h expected %h", cyc, tx_data, q_data[m_owner][0]);
         end
      end
      if (busy === 1'b1) busy_cycles++;
      if (req_ready[2] === 1'b1 && grant_id !== 2'd2) rdy2_bad++;
      if (timeout === 1'b1) to_cyc.push_back(cyc);
      if (tx_valid === 1'b1 && tx_ready) begin
         log_id.push_back(int'(grant_id)); log_byte.push_back(tx_data); log_cyc.push_back(cyc);
      end

      hs = exp_valid && tx_ready;
      m_tpulse = 0;
      if (!m_locked) begin
         found = 0;
         for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!found && drv_valid[idx]) begin
               found = 1; m_owner = idx; m_locked = 1; m_stall = 0;
            end
         end
      end else if (hs) begin
         lst = q_last[m_owner][0];
         void'(q_data[m_owner].pop_front());
         void'(q_last[m_owner].pop_front());
         m_stall = 0;
         if (lst) begin
            m_locked = 0; m_last = m_owner;
         end
      end else if (!drv_valid[m_owner]) begin
         m_stall++;
         if (m_stall == TO) begin
            m_locked = 0; m_last = m_owner; m_stall = 0; m_tpulse = 1;
         end
      end
      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks += 5;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
      if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      repeat (3) step();
   endtask

   task automatic test_single_packet();
      logic [7:0] exp_b [3];
      exp_b = '{8'h41, 8'h42, 8'h43};
      apply_reset();
      rdy_mode = 0; gaps = 0;
      push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
      repeat (5) step();
      n_checks += 2;
      if (log_id.size() != 3) begin n_fail++; $display("FAIL single_count: got %0d expected 3", log_id.size()); end
      if (busy_cycles != 3) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected 3", busy_cycles); end
      for (int i = 0; i < 3 && i < log_id.size(); i++) begin
         n_checks++;
         if (log_id[i] != 1 || log_byte[i] !== exp_b[i] || log_cyc[i] != i + 1) begin
            n_fail++;
            $display("FAIL single_byte%0d: got id=%0d byte=%h cyc=%0d expected id=1 byte=%h cyc=%0d",
                     i, log_id[i], log_byte[i], log_cyc[i], exp_b[i], i + 1);
         end
      end
   endtask

   task automatic test_round_robin();
      int exp_id [6];
      exp_id = '{0, 1, 2, 3, 0, 1};
      apply_reset();
      rdy_mode = 0; gaps = 0;
      for (int r = 0; r < N; r++) push(r, 8'hA0 + 8'(r), 1);
      push(0, 8'hB0, 1); push(1, 8'hB1, 1);
      repeat (13) step();
      n_checks++;
      if (log_id.size() != 6) begin n_fail++; $display("FAIL rr_count: got %0d expected 6", log_id.size()); end
      for (int i = 0; i < 6 && i < log_id.size(); i++) begin
         n_checks++;
         if (log_id[i] != exp_id[i] || log_cyc[i] != 2 * i + 1) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got id=%0d cyc=%0d expected id=%0d cyc=%0d",
                     i, log_id[i], log_cyc[i], exp_id[i], 2 * i + 1);
         end
      end
   endtask

   task automatic test_no_interleave();
      int         exp_id [6];
      logic [7:0] exp_b [6];
      exp_id = '{0, 0, 0, 0, 2, 2};
      exp_b  = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1};
      apply_reset();
      rdy_mode = 0; gaps = 0;
      for (int j = 0; j < 4; j++) push(0, 8'hC0 + 8'(j), j == 3);
      push(2, 8'hD0, 0); push(2, 8'hD1, 1);
      repeat (9) step();
      n_checks += 2;
      if (log_id.size() != 6) begin n_fail++; $display("FAIL nointl_count: got %0d expected 6", log_id.size()); end
      if (rdy2_bad != 0) begin n_fail++; $display("FAIL nointl_ready2: got %0d cycles expected 0", rdy2_bad); end
      for (int i = 0; i < 6 && i < log_id.size(); i++) begin
         n_checks++;
         if (log_id[i] != exp_id[i] || log_byte[i] !== exp_b[i]) begin
            n_fail++;
            $display("FAIL nointl_byte%0d: got id=%0d byte=%h expected id=%0d byte=%h",
                     i, log_id[i], log_byte[i], exp_id[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      gaps = 0;
      push(3, 8'h5A, 1);
      rdy_mode = 1;
      repeat (21) step();
      n_checks += 3;
      if (to_cyc.size() != 0) begin n_fail++; $display("FAIL bp_no_timeout: got %0d pulses expected 0", to_cyc.size()); end
      if (busy_cycles != 20) begin n_fail++; $display("FAIL bp_busy_hold: got %0d expected 20", busy_cycles); end
      if (log_id.size() != 0) begin n_fail++; $display("FAIL bp_early_xfer: got %0d expected 0", log_id.size()); end
      rdy_mode = 0;
      repeat (2) step();
      n_checks++;
      if (log_id.size() != 1 || log_id[0] != 3 || log_byte[0] !== 8'h5A || log_cyc[0] != 21) begin
         n_fail++;
         $display("FAIL bp_release: got n=%0d expected one byte 5a from 3 at cyc 21", log_id.size());
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      rdy_mode = 0; gaps = 0;
      push(2, 8'h10, 0);
      push(3, 8'h77, 1);
      repeat (21) step();
      n_checks += 3;
      if (to_cyc.size() != 1 || to_cyc[0] != 18) begin
         n_fail++;
         $display("FAIL to_pulse: got %0d pulses first at %0d expected 1 pulse at 18",
                  to_cyc.size(), (to_cyc.size() > 0) ? to_cyc[0] : -1);
      end
      if (busy_cycles != 18) begin n_fail++; $display("FAIL to_busy_cycles: got %0d expected 18", busy_cycles); end
      if (log_id.size() != 2 || log_id[0] != 2 || log_byte[0] !== 8'h10 ||
          log_id[1] != 3 || log_byte[1] !== 8'h77 || log_cyc[1] != 19) begin
         n_fail++;
         $display("FAIL to_next_grant: got n=%0d expected 10 from 2 then 77 from 3 at cyc 19", log_id.size());
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      rdy_mode = 0; gaps = 0;
      for (int j = 0; j < 5; j++) push(1, 8'hE0 + 8'(j), j == 4);
      repeat (2) step();
      drive_inputs();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hE1) begin
         n_fail++; $display("FAIL rmid_second_byte: got v=%b d=%h expected v=1 d=e1", tx_valid, tx_data);
      end
      @(posedge clk); #1;
      n_checks += 4;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_valid: got %b expected 0", tx_valid); end
      if (req_ready !== 4'b0) begin n_fail++; $display("FAIL rmid_req_ready: got %b expected 0000", req_ready); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rmid_grant_id: got %0d expected 0", grant_id); end
      reset = 1'b0;
      model_reset();
      for (int r = 0; r < N; r++) push(r, 8'hF0 + 8'(r), 1);
      repeat (3) step();
      n_checks++;
      if (log_id.size() < 1 || log_id[0] != 0) begin
         n_fail++; $display("FAIL rmid_first_grant: got %0d expected 0", (log_id.size() > 0) ? log_id[0] : -1);
      end
   endtask

   task automatic test_random();
      int r, len, guard;
      bit pending;
      apply_reset();
      gaps = 1; rdy_mode = 2;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) push(r, 8'($urandom), j == len - 1);
         end
         step();
      end
      gaps = 0; rdy_mode = 0;
      guard = 0;
      pending = 1;
      while (pending && guard < 400) begin
         pending = m_locked;
         for (int i = 0; i < N; i++) if (q_data[i].size() > 0) pending = 1;
         if (pending) step();
         guard++;
      end
      n_checks += 2;
      if (pending) begin n_fail++; $display("FAIL rand_drain: got queues pending after %0d cycles expected empty", guard); end
      if (log_id.size() != pushed) begin
         n_fail++; $display("FAIL rand_byte_count: got %0d expected %0d", log_id.size(), pushed);
      end
   endtask

   initial begin
      reset = 1'b1; tx_ready = 1'b0; rdy_mode = 0; gaps = 0;
      for (int i = 0; i < N; i++) begin
         drv_valid[i] = 1'b0; drv_data[i] = 8'h00; drv_last[i] = 1'b0;
      end
      model_reset();
      test_reset();
      test_single_packet();
      test_round_robin();
      test_no_interleave();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
